// File: rtl/spark_pwm.sv
// Servo-style PWM for a SPARK motor controller: fixed-period frames with a
// pulse width of neutral +/- a ratio-scaled span, latched only at frame start.
//
// Ports:
//   clock          system clock, all state on the rising edge
//   reset_n        asynchronous active-low reset
//   pwm_enable     1 = generate frames, 0 = hold counters at 0, output low
//   pwm_direction  0 = pulse above neutral, 1 = pulse below neutral
//   pwm_ratio      speed magnitude, 0 = stop, 255 = full scale
//   pwm_update     level; 1 = take ratio/direction at the next frame start
//   pwm_signal     registered PWM output
module spark_pwm #(
  parameter int CLKS_PER_US = 50,
  parameter int PERIOD_US   = 5000,
  parameter int NEUTRAL_US  = 1500,
  parameter int SPAN_US     = 500
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_direction,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_update,
  output logic       pwm_signal
);

  localparam int PW = $clog2(CLKS_PER_US + 1);
  localparam int UW = $clog2(PERIOD_US + 1);

  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_US - 1);
  localparam logic [UW-1:0] UMAX = UW'(PERIOD_US - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [UW-1:0] us_q, us_d;
  logic [7:0]    ratio_q, ratio_d;
  logic          dir_q, dir_d;
  logic          pwm_q, pwm_d;

  logic        us_tick;
  logic        frame_start;
  logic        load;
  logic [31:0] prod;
  logic [31:0] off_us;
  logic [31:0] width_us;

  assign us_tick     = (presc_q == PMAX);
  assign frame_start = pwm_enable
                     && (presc_q == '0)
                     && (us_q == '0);
  assign load        = frame_start && pwm_update;

  // Latched values as they will be for this edge, so the first
  // clock of a frame already uses the freshly accepted ratio.
  always_comb begin
    ratio_d = ratio_q;
    dir_d   = dir_q;
    if (load) begin
      ratio_d = pwm_ratio;
      dir_d   = pwm_direction;
    end
  end

  // 32-bit product: 255 * SPAN_US fits with plenty of margin.
  always_comb begin
    prod   = 32'(ratio_d) * 32'(SPAN_US);
    off_us = prod >> 8;
    if (dir_d) begin
      width_us = 32'(NEUTRAL_US) - off_us;
    end else begin
      width_us = 32'(NEUTRAL_US) + off_us;
    end
  end

  always_comb begin
    presc_d = presc_q;
    us_d    = us_q;
    pwm_d   = 1'b0;
    if (!pwm_enable) begin
      presc_d = '0;
      us_d    = '0;
    end else begin
      if (us_tick) begin
        presc_d = '0;
        if (us_q == UMAX) begin
          us_d = '0;
        end else begin
          us_d = us_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
      pwm_d = (32'(us_q) < width_us);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      us_q    <= '0;
      ratio_q <= '0;
      dir_q   <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      us_q    <= us_d;
      ratio_q <= ratio_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_signal = pwm_q;

endmodule

// File: tb/tb_spark_pwm.sv
// Bench for spark_pwm with scaled-down timing parameters.
// Directed frame checks plus randomized traffic against a frame-phase model.
module tb_spark_pwm;

  localparam int C = 2;
  localparam int P = 60;
  localparam int N = 30;
  localparam int S = 20;
  localparam int FRAME = P * C;

  logic       clock;
  logic       reset_n;
  logic       pwm_enable;
  logic       pwm_direction;
  logic [7:0] pwm_ratio;
  logic       pwm_update;
  logic       pwm_signal;

  int checks = 0;
  int errors = 0;

  int   nextpos = 0;
  int   m_ratio = 0;
  logic m_dir   = 1'b0;
  logic exp_pwm = 1'b0;
  int   hi      = 0;
  int   h;

  spark_pwm #(
    .CLKS_PER_US(C),
    .PERIOD_US  (P),
    .NEUTRAL_US (N),
    .SPAN_US    (S)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pwm_enable   (pwm_enable),
    .pwm_direction(pwm_direction),
    .pwm_ratio    (pwm_ratio),
    .pwm_update   (pwm_update),
    .pwm_signal   (pwm_signal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int width_us(int r, logic d);
    int off;
    off = (r * S) / 256;
    return d ? N - off : N + off;
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    nextpos = 0;
    m_ratio = 0;
    m_dir   = 1'b0;
    exp_pwm = 1'b0;
  endtask

  // One clock: advance the model on the edge, compare at the falling edge.
  task automatic cyc();
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else if (!pwm_enable) begin
      nextpos = 0;
      exp_pwm = 1'b0;
    end else begin
      if (nextpos == 0 && pwm_update) begin
        m_ratio = int'(pwm_ratio);
        m_dir   = pwm_direction;
      end
      exp_pwm = ((nextpos / C) < width_us(m_ratio, m_dir));
      nextpos = (nextpos + 1) % FRAME;
    end
    @(negedge clock);
    chk("pwm", pwm_signal, exp_pwm);
    if (pwm_signal) hi++;
  endtask

  task automatic align();
    for (int k = 0; k < FRAME && nextpos != 0; k++) cyc();
  endtask

  // One full frame; optional input change at clock chg_at of the frame.
  task automatic frame(input int chg_at, input logic [7:0] r,
                       input logic d, input logic u, output int highs);
    align();
    hi = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == chg_at) begin
        pwm_ratio     = r;
        pwm_direction = d;
        pwm_update    = u;
      end
      cyc();
    end
    highs = hi;
  endtask

  task automatic set_in(logic [7:0] r, logic d, logic u);
    pwm_ratio     = r;
    pwm_direction = d;
    pwm_update    = u;
  endtask

  initial begin
    reset_n    = 1'b0;
    pwm_enable = 1'b0;
    set_in(8'd0, 1'b0, 1'b0);
    #2;
    chk("reset_pwm", pwm_signal, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc();

    // ratio 128 forward: 40 us -> 80 clocks
    pwm_enable = 1'b1;
    set_in(8'd128, 1'b0, 1'b1);
    frame(-1, 8'd0, 1'b0, 1'b0, h);
    chk_int("fwd128", h, 80);
    // mid-frame change must not disturb the current frame
    frame(30, 8'd255, 1'b0, 1'b1, h);
    chk_int("midchg_cur", h, 80);
    frame(-1, 8'd0, 1'b0, 1'b0, h);
    chk_int("fwd255", h, 98);

    // reverse and zero ratio
    frame(0, 8'd128, 1'b1, 1'b1, h);
    chk_int("rev128", h, 40);
    frame(0, 8'd255, 1'b1, 1'b1, h);
    chk_int("rev255", h, 22);
    frame(0, 8'd0, 1'b1, 1'b1, h);
    chk_int("rev0", h, 60);
    frame(0, 8'd0, 1'b0, 1'b1, h);
    chk_int("fwd0", h, 60);

    // hold while update is low
    frame(0, 8'd255, 1'b1, 1'b1, h);
    chk_int("hold_pre", h, 22);
    frame(0, 8'd150, 1'b1, 1'b0, h);
    chk_int("hold1", h, 22);
    frame(-1, 8'd0, 1'b0, 1'b0, h);
    chk_int("hold2", h, 22);
    frame(0, 8'd150, 1'b1, 1'b1, h);
    chk_int("rev150", h, 38);

    // enable drop mid-pulse, then restart with a fresh frame
    align();
    for (int k = 0; k < 10; k++) cyc();
    pwm_enable = 1'b0;
    cyc();
    chk("en_drop", pwm_signal, 1'b0);
    for (int k = 0; k < 15; k++) cyc();
    pwm_enable = 1'b1;
    frame(-1, 8'd0, 1'b0, 1'b0, h);
    chk_int("en_restart", h, 38);

    // asynchronous reset mid-pulse
    align();
    for (int k = 0; k < 10; k++) cyc();
    reset_n = 1'b0;
    #1;
    chk("async_rst", pwm_signal, 1'b0);
    model_reset();
    for (int k = 0; k < 3; k++) cyc();
    pwm_update = 1'b0;
    reset_n = 1'b1;
    frame(-1, 8'd0, 1'b0, 1'b0, h);
    chk_int("rst_neutral1", h, 60);
    frame(-1, 8'd0, 1'b0, 1'b0, h);
    chk_int("rst_neutral2", h, 60);

    // randomized traffic checked every clock against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_in(8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 299) == 0) begin
        pwm_enable = ~pwm_enable;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spark_pwm.md
SPARK_PWM -- requirements
Module: spark_pwm

Interface
REQ-001 Parameter CLKS_PER_US, default 50, clock cycles per microsecond tick.
REQ-002 Parameter PERIOD_US, default 5000, PWM frame period in microseconds; SHALL exceed NEUTRAL_US+SPAN_US.
REQ-003 Parameter NEUTRAL_US, default 1500, stopped-motor pulse width in microseconds.
REQ-004 Parameter SPAN_US, default 500, full-scale pulse deviation in microseconds.
REQ-005 clock  input  1  single system clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 pwm_enable  input  1  1 = generate frames, 0 = output idle low.
REQ-008 pwm_direction  input  1  0 = forward (pulse above neutral), 1 = reverse (pulse below neutral).
REQ-009 pwm_ratio  input  8  speed magnitude, 0 = stop, 255 = full.
REQ-010 pwm_update  input  1  level; 1 = accept ratio/direction at next frame start, 0 = hold last accepted values.
REQ-011 pwm_signal  output  1  registered servo-style PWM to motor controller.

Function
REQ-012 Prescaler SHALL count 0..CLKS_PER_US-1 and emit a one-clock us_tick on its terminal count; us_cnt SHALL count 0..PERIOD_US-1 on us_tick, then wrap to 0.
REQ-013 Frame start = us_cnt==0 with prescaler==0; frame length SHALL be exactly PERIOD_US*CLKS_PER_US clocks.
REQ-014 At each frame start, if pwm_update==1, latched ratio/direction SHALL load from pwm_ratio/pwm_direction; otherwise previous latched values SHALL persist.
REQ-015 Mid-frame changes to pwm_ratio, pwm_direction or pwm_update SHALL NOT affect the current frame.
REQ-016 offset_us = floor(latched_ratio * SPAN_US / 256), computed at ≥18-bit width with no overflow (range 0..498 at defaults).
REQ-017 width_us = NEUTRAL_US + offset_us if latched direction 0; NEUTRAL_US - offset_us if 1.
REQ-018 pwm_signal SHALL be 1 while us_cnt < width_us and 0 otherwise, registered: high for exactly width_us*CLKS_PER_US clocks from frame start.
REQ-019 While pwm_enable==0: prescaler and us_cnt held at 0, pwm_signal 0 from the clock after enable is sampled low; latched values retained.
REQ-020 Enable rise: first frame SHALL start on the first clock edge sampling pwm_enable==1 (latch rule REQ-014 applies there); pwm_signal rises one clock later.
REQ-021 Enable dropping mid-pulse SHALL truncate the pulse on the next clock; no partial frame resumes later.
REQ-022 Ratio 0 in either direction SHALL give exactly NEUTRAL_US pulses.
REQ-023 Design SHALL contain no other clock domains or combinational output paths.

Reset
REQ-024 reset_n low SHALL immediately clear pwm_signal=0, prescaler=0, us_cnt=0, latched ratio=0, latched direction=0, regardless of clock.
REQ-025 After reset_n deassertion, behaviour follows REQ-019/REQ-020; with pwm_enable=1 and update never asserted, frames carry 1500 µs neutral pulses.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no pulse remnant after release.

Verification
REQ-027 Reset release, enable=1, update=1, ratio=128, dir=0 -> pulse 1750 µs (87,500 clocks) every 5000 µs (250,000 clocks).
REQ-028 Then ratio=255 mid-frame -> current frame unchanged; following frames 1998 µs.
REQ-029 dir=1, ratio=128 then 255 -> pulses 1250 µs, then 1002 µs; ratio=0 either direction -> 1500 µs.
REQ-030 update=0, ratio=150 -> pulses stay at last accepted width (1002 µs) indefinitely; update=1 -> next frame 1208 µs (dir=1).
REQ-031 enable=0 mid-pulse -> pwm_signal 0 next clock and stays 0; enable=1 again -> new full frame starts, rising one clock after enable sampled.
REQ-032 reset_n pulsed low mid-pulse -> pwm_signal 0 asynchronously; after release with enable=1, update=0 -> 1500 µs neutral pulses.
